pos_cell_reader: RTL and testbench
==================================

POS_CELL_READER -- requirements
Module: pos_cell_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 96, width of one memory word: {posz, posy, posx}, 32 bits each.
REQ-002 Parameter PARTICLE_NUM, default 220, number of words in the cell memory.
REQ-003 Parameter ADDR_WIDTH, default 8, cell memory address width.
REQ-004 Parameter FIFO_DEPTH, default 4, output buffer depth; power of two, minimum 4.
REQ-005 clk  in  1  sole clock; all logic is rising-edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  one-cycle request to stream the whole cell; ignored unless busy=0.
REQ-008 busy  out  1  high from the cycle after an accepted start until the cycle done pulses.
REQ-009 done  out  1  one-cycle pulse after the last particle handshake, or after reading a count of 0.
REQ-010 cnt_err  out  1  sticky per run; set when the stored count exceeds PARTICLE_NUM-1; cleared by the next accepted start.
REQ-011 particle_count  out  ADDR_WIDTH  count latched from address 0, after clamping.
REQ-012 mem_address  out  ADDR_WIDTH  cell memory read address.
REQ-013 mem_rden  out  1  cell memory read enable.
REQ-014 mem_wren  out  1  tied 0.
REQ-015 mem_data  out  DATA_WIDTH  tied 0.
REQ-016 mem_q  in  DATA_WIDTH  cell memory read data; valid exactly 2 cycles after the mem_rden cycle.
REQ-017 out_valid / out_ready  out / in  1 / 1  particle stream handshake; a transfer occurs when both are high.
REQ-018 out_data  out  DATA_WIDTH  particle position word.
REQ-019 out_last  out  1  high with the final particle of a run.

Function
REQ-020 The state machine SHALL have states IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN and DONE.
- IDLE -> RD_CNT on start.
- RD_CNT issues mem_rden with address 0 for one cycle, then goes to WAIT_CNT.
- WAIT_CNT waits 2 cycles, latches mem_q[ADDR_WIDTH-1:0], then goes to DONE if the count is 0, otherwise to STREAM.
- STREAM issues reads to addresses 1..count, then goes to DRAIN.
- DRAIN waits until the in-flight count and the FIFO are both empty, then goes to DONE.
- DONE pulses done and returns to IDLE.
REQ-021 A count greater than PARTICLE_NUM-1 SHALL be clamped to PARTICLE_NUM-1 and SHALL set cnt_err.
REQ-022 In STREAM, a read SHALL be issued only when (in-flight reads + FIFO occupancy) < FIFO_DEPTH, so returning data is never dropped.
REQ-023 Each return word SHALL be pushed into the FIFO exactly 2 cycles after its read, tagged with last = (address == count).
REQ-024 out_valid SHALL equal FIFO non-empty; out_data and out_last SHALL come from the FIFO head and hold stable while out_valid=1 and out_ready=0.
REQ-025 With out_ready held at 1, the block SHALL sustain one particle per cycle; the first particle appears no later than 6 cycles after start.
REQ-026 A push and a pop in the same cycle SHALL leave occupancy unchanged.
REQ-027 The in-flight counter SHALL be 2 bits wide and SHALL count reads issued but not yet returned.
REQ-028 mem_rden SHALL be 0 in IDLE, DRAIN and DONE; mem_address SHALL hold its last value when mem_rden=0.
REQ-029 start asserted while busy=1 SHALL be ignored, with no effect on the current run.

Reset
REQ-030 While rst=1, state SHALL be IDLE and busy, done, cnt_err, mem_rden, out_valid and out_last SHALL be 0.
REQ-031 While rst=1, particle_count, mem_address, the FIFO pointers and the in-flight counter SHALL be 0.
REQ-032 A reset during a run SHALL abort the run; any read data returning after reset is released SHALL be discarded.

Structure
REQ-033 The state enum and the 2-cycle read-latency constant SHALL live in the shared MD package, for reuse by the matching cell writer.
REQ-034 The output buffer SHALL be a single sub-module, pos_reader_fifo: synchronous, FIFO_DEPTH x (DATA_WIDTH+1), first-word-fall-through.

Verification
REQ-035 Count=5, out_ready=1: exactly 5 transfers, addresses 1..5 in order, out_last on the 5th, done 1 cycle after the 5th transfer.
REQ-036 Count=0: no out_valid at any time; done pulses in the cycle after WAIT_CNT ends; particle_count=0.
REQ-037 Count=219, out_ready random at 30%: all 219 words delivered in address order, none dropped or duplicated, and in-flight + occupancy never exceeds 4.
REQ-038 Count=250: cnt_err=1, particle_count=219, 219 words delivered; the next start clears cnt_err.
REQ-039 rst asserted mid-STREAM after 3 transfers: all outputs reach reset values immediately; after release, no stale out_valid; a new start with count=2 yields exactly 2 words.
REQ-040 start pulsed while busy=1 with count=3: the run still delivers exactly 3 words and a single done pulse.

Source files
------------

// File: rtl/pos_cell_reader_pkg.sv
// Shared MD cell-memory definitions: controller states and the read latency
// of the cell memory, used by both the cell reader and the cell writer.
package pos_cell_reader_pkg;

    localparam int RD_LAT = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_CNT,
        ST_WAIT_CNT,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } rd_state_t;

endpackage

// File: rtl/pos_reader_fifo.sv
// First-word-fall-through output buffer for the cell reader; head is valid
// whenever the buffer is non-empty.
module pos_reader_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 97
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && ((count != (AW+1)'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/pos_cell_reader.sv
// Streams every particle position of one cell memory out on a ready/valid
// port: reads the count at address 0, then words 1..count with credit flow control.
module pos_cell_reader
    import pos_cell_reader_pkg::*;
#(
    parameter int DATA_WIDTH   = 96,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  cnt_err,
    output logic [ADDR_WIDTH-1:0] particle_count,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_rden,
    output logic                  mem_wren,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

    rd_state_t             state, state_n;
    logic [1:0]            wait_cnt;
    logic [1:0]            inflight;
    logic [RD_LAT-1:0]     vld_pipe, last_pipe;
    logic [ADDR_WIDTH-1:0] rd_ptr, addr_hold, rd_addr, raw_cnt;
    logic                  issue, issue_last, ret, pop, fifo_empty;
    logic                  wait_last, drain_ok, can_issue;
    logic [CW-1:0]         fifo_cnt;
    logic [CW:0]           credit_used;
    logic [DATA_WIDTH:0]   head;

    assign mem_wren    = 1'b0;
    assign mem_data    = '0;
    assign mem_address = rd_addr;
    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);

    assign raw_cnt     = mem_q[ADDR_WIDTH-1:0];
    assign wait_last   = (wait_cnt == 2'(RD_LAT - 1));
    assign ret         = vld_pipe[RD_LAT-1];
    assign issue_last  = (rd_ptr == particle_count);

    // Reads in flight plus buffered words may never exceed the buffer depth,
    // so every returning word has a slot waiting for it.
    assign credit_used = {1'b0, fifo_cnt} + {{(CW-1){1'b0}}, inflight};
    assign can_issue   = (credit_used < (CW+1)'(FIFO_DEPTH));

    assign out_valid   = !fifo_empty;
    assign pop         = out_valid && out_ready;
    assign out_data    = head[DATA_WIDTH-1:0];
    assign out_last    = !fifo_empty && head[DATA_WIDTH];

    // Leave DRAIN in the same cycle the final word is taken, so done follows it directly.
    assign drain_ok    = (inflight == 2'd0) &&
                         (fifo_empty || (fifo_cnt == CW'(1) && pop));

    always_comb begin
        state_n  = state;
        mem_rden = 1'b0;
        rd_addr  = addr_hold;
        issue    = 1'b0;
        case (state)
            ST_IDLE:     if (start) state_n = ST_RD_CNT;
            ST_RD_CNT: begin
                mem_rden = 1'b1;
                rd_addr  = '0;
                state_n  = ST_WAIT_CNT;
            end
            ST_WAIT_CNT: if (wait_last) state_n = (raw_cnt == '0) ? ST_DONE : ST_STREAM;
            ST_STREAM: begin
                if (can_issue) begin
                    issue    = 1'b1;
                    mem_rden = 1'b1;
                    rd_addr  = rd_ptr;
                    if (issue_last) state_n = ST_DRAIN;
                end
            end
            ST_DRAIN:    if (drain_ok) state_n = ST_DONE;
            ST_DONE:     state_n = ST_IDLE;
            default:     state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            wait_cnt       <= '0;
            inflight       <= '0;
            vld_pipe       <= '0;
            last_pipe      <= '0;
            rd_ptr         <= '0;
            addr_hold      <= '0;
            particle_count <= '0;
            cnt_err        <= 1'b0;
        end else begin
            state     <= state_n;
            addr_hold <= rd_addr;
            vld_pipe  <= {vld_pipe[RD_LAT-2:0], issue};
            last_pipe <= {last_pipe[RD_LAT-2:0], issue && issue_last};
            inflight  <= inflight + {1'b0, issue} - {1'b0, ret};

            if (state == ST_IDLE && start) cnt_err <= 1'b0;

            if (state == ST_RD_CNT)        wait_cnt <= '0;
            else if (state == ST_WAIT_CNT) wait_cnt <= wait_cnt + 2'd1;

            if (state == ST_WAIT_CNT && wait_last) begin
                particle_count <= (raw_cnt > MAX_CNT) ? MAX_CNT : raw_cnt;
                cnt_err        <= (raw_cnt > MAX_CNT);
                rd_ptr         <= ADDR_WIDTH'(1);
            end else if (issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    pos_reader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (ret),
        .push_data ({last_pipe[RD_LAT-1], mem_q}),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );

endmodule

// File: tb/tb_pos_cell_reader.sv
// Directed bench for pos_cell_reader: behavioural 2-cycle cell memory,
// stream monitor with per-word data/last checks and a credit bound check.
module tb_pos_cell_reader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, cnt_err;
    logic [7:0]  particle_count, mem_address;
    logic        mem_rden, mem_wren;
    logic [95:0] mem_data;
    logic [95:0] mem_q = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [95:0] out_data;
    logic        out_last;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cnt_val = 0;
    int exp_n = 0;
    int rdy_mode = 0;
    int xfer_n, done_n, valid_seen, issued;
    int start_cyc, first_valid_cyc, first_xfer_cyc, last_xfer_cyc, done_cyc;
    logic mon_en = 1'b0;

    pos_cell_reader dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .cnt_err(cnt_err), .particle_count(particle_count),
        .mem_address(mem_address), .mem_rden(mem_rden), .mem_wren(mem_wren),
        .mem_data(mem_data), .mem_q(mem_q), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [95:0] word(input int k);
        return {32'h3000_0000 + 32'(k), 32'h2000_0000 + 32'(k), 32'h1000_0000 + 32'(k)};
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Cell memory: data for a read issued in cycle t is on mem_q during t+2.
    logic       m_v1 = 1'b0;
    logic [7:0] m_a1 = '0;
    always @(posedge clk) begin
        m_v1 <= mem_rden;
        m_a1 <= mem_address;
        if (m_v1) mem_q <= (m_a1 == 8'd0) ? {64'b0, 32'(cnt_val)} : word(int'(m_a1));
    end

    // out_ready pattern: mode 0 always ready, mode 1 ready 30% of cycles.
    initial forever begin
        @(posedge clk);
        #1 out_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 30);
    end

    always @(negedge clk) begin
        if (!rst && mon_en) begin
            if (mem_rden && mem_address != 8'd0) begin
                check("credit", 128'((issued - xfer_n + 1) <= 4), 128'(1));
                issued++;
            end
            if (out_valid) begin
                if (valid_seen == 0) first_valid_cyc = cyc;
                valid_seen++;
            end
            if (out_valid && out_ready) begin
                xfer_n++;
                if (xfer_n == 1) first_xfer_cyc = cyc;
                last_xfer_cyc = cyc;
                check("data", 128'(out_data), 128'(word(xfer_n)));
                check("last", 128'(out_last), 128'(xfer_n == exp_n));
            end
            if (done) begin
                done_n++;
                done_cyc = cyc;
            end
        end
    end

    task automatic clear_mon();
        xfer_n = 0; done_n = 0; valid_seen = 0; issued = 0;
        first_valid_cyc = 0; first_xfer_cyc = 0; last_xfer_cyc = 0; done_cyc = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        start_cyc = cyc + 1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 5000 && done_n == 0; i++) @(negedge clk);
        check("done_seen", 128'(done_n != 0), 128'(1));
        repeat (3) @(negedge clk);
    endtask

    task automatic setup(input int n, input int mode);
        cnt_val  = n;
        exp_n    = (n > 219) ? 219 : n;
        rdy_mode = mode;
        clear_mon();
    endtask

    initial begin
        clear_mon();
        // Reset values
        repeat (2) @(negedge clk);
        check("rst_busy",  128'(busy), 128'(0));
        check("rst_done",  128'(done), 128'(0));
        check("rst_err",   128'(cnt_err), 128'(0));
        check("rst_rden",  128'(mem_rden), 128'(0));
        check("rst_valid", 128'(out_valid), 128'(0));
        check("rst_last",  128'(out_last), 128'(0));
        check("rst_pcnt",  128'(particle_count), 128'(0));
        check("rst_addr",  128'(mem_address), 128'(0));
        check("wren",      128'(mem_wren), 128'(0));
        check("wdata",     128'(mem_data), 128'(0));
        @(posedge clk); #1 rst = 1'b0;
        mon_en = 1'b1;

        // Count 5, always ready
        setup(5, 0);
        pulse_start();
        wait_done();
        check("c5_xfers", 128'(xfer_n), 128'(5));
        check("c5_done1", 128'(done_n), 128'(1));
        check("c5_done_lat", 128'(done_cyc - last_xfer_cyc), 128'(1));
        check("c5_first_lat", 128'((first_valid_cyc - start_cyc) <= 6), 128'(1));
        check("c5_rate", 128'(last_xfer_cyc - first_xfer_cyc), 128'(4));
        check("c5_pcnt", 128'(particle_count), 128'(5));
        check("c5_busy", 128'(busy), 128'(0));

        // Count 0: no stream, done right after WAIT_CNT
        setup(0, 0);
        pulse_start();
        wait_done();
        check("c0_valid", 128'(valid_seen), 128'(0));
        check("c0_done_lat", 128'(done_cyc - start_cyc), 128'(3));
        check("c0_pcnt", 128'(particle_count), 128'(0));
        check("c0_done1", 128'(done_n), 128'(1));

        // Full cell with a sparse consumer
        setup(219, 1);
        pulse_start();
        wait_done();
        check("c219_xfers", 128'(xfer_n), 128'(219));
        check("c219_err", 128'(cnt_err), 128'(0));
        check("c219_pcnt", 128'(particle_count), 128'(219));

        // Oversized count is clamped and flagged
        setup(250, 0);
        pulse_start();
        wait_done();
        check("c250_err", 128'(cnt_err), 128'(1));
        check("c250_pcnt", 128'(particle_count), 128'(219));
        check("c250_xfers", 128'(xfer_n), 128'(219));
        setup(1, 0);
        pulse_start();
        @(negedge clk);
        check("err_clear", 128'(cnt_err), 128'(0));
        wait_done();
        check("c1_xfers", 128'(xfer_n), 128'(1));

        // Reset in the middle of a stream
        setup(10, 0);
        pulse_start();
        for (int i = 0; i < 200 && xfer_n < 3; i++) @(negedge clk);
        check("pre_rst_xfers", 128'(xfer_n), 128'(3));
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_busy",  128'(busy), 128'(0));
        check("mid_valid", 128'(out_valid), 128'(0));
        check("mid_rden",  128'(mem_rden), 128'(0));
        check("mid_last",  128'(out_last), 128'(0));
        check("mid_done",  128'(done), 128'(0));
        check("mid_addr",  128'(mem_address), 128'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_mon();
        repeat (8) @(negedge clk);
        check("stale_valid", 128'(valid_seen), 128'(0));
        check("stale_busy", 128'(busy), 128'(0));
        setup(2, 0);
        pulse_start();
        wait_done();
        check("post_rst_xfers", 128'(xfer_n), 128'(2));

        // start while busy is ignored
        setup(3, 0);
        pulse_start();
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();
        repeat (10) @(negedge clk);
        check("rs_xfers", 128'(xfer_n), 128'(3));
        check("rs_done1", 128'(done_n), 128'(1));
        check("rs_busy", 128'(busy), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
